traffic_countdown_display: RTL

Downstream consumer of the two-direction traffic light controller outputs.
- Tracks each direction's 3-bit light code [Red,Yellow,Green] and runs a per-direction seconds countdown, reloaded on every phase change.
- Drives a 4-digit multiplexed active-low 7-segment display.
- Also generates the 1 Hz strobe that paces the countdown.

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/traffic_countdown_display_phase.sv | 48 ++++
 rtl/traffic_countdown_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic countdown display:
// light codes, active-low 7-segment patterns, digit slot encoding, BCD split.
package traffic_pkg;

    // Light codes as {R,Y,G}
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Display slot order, one slot per scan period
    typedef enum logic [1:0] {
        DIG_D1_UNITS = 2'd0,
        DIG_D1_TENS  = 2'd1,
        DIG_D2_UNITS = 2'd2,
        DIG_D2_TENS  = 2'd3
    } digit_idx_e;

    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Counts never exceed 31, so three thresholds cover every tens value
    function automatic logic [1:0] bcd_tens(input logic [4:0] v);
        return (v >= 5'd30) ? 2'd3 : (v >= 5'd20) ? 2'd2 : (v >= 5'd10) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [3:0] bcd_units(input logic [4:0] v, input logic [1:0] tens);
        return 4'(v - ({3'b000, tens} * 5'd10));
    endfunction

endpackage

// File: rtl/traffic_countdown_display_phase.sv
// phase_countdown: per-direction seconds countdown. Reloads on any change of
// the light code, otherwise decrements on each second tick and saturates at 0.
module phase_countdown
    import traffic_pkg::*;
#(
    parameter int unsigned RED_TIME    = 20,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned GREEN_TIME  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light,
    input  logic       tick,
    output logic [4:0] cnt,
    output logic       invalid
);

    logic [2:0] prev_q;
    logic [4:0] reload;

    // Reload value selected by the incoming code; non-one-hot codes load 0
    always_comb begin
        reload = 5'd0;
        case (light)
            LIGHT_RED:    reload = 5'(RED_TIME);
            LIGHT_YELLOW: reload = 5'(YELLOW_TIME);
            LIGHT_GREEN:  reload = 5'(GREEN_TIME);
            default:      reload = 5'd0;
        endcase
    end

    // A code change wins over a tick in the same cycle; that tick is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 3'b000;
            cnt    <= 5'd0;
        end else if (light != prev_q) begin
            prev_q <= light;
            cnt    <= reload;
        end else if (tick && (cnt != 5'd0)) begin
            cnt <= cnt - 5'd1;
        end
    end

    assign invalid = !((prev_q == LIGHT_RED) || (prev_q == LIGHT_YELLOW) ||
                       (prev_q == LIGHT_GREEN));

endmodule

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: 1 Hz prescaler, two phase countdowns and a
// 4-digit multiplexed active-low 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a tens digit of 0.
module traffic_countdown_display
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned RED_TIME    = 20,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned GREEN_TIME  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light1,
    input  logic [2:0] light2,
    output logic       sec_tick,
    output logic [4:0] cnt1,
    output logic [4:0] cnt2,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TICK_W-1:0] presc_q;
    logic [SCAN_W-1:0] scan_q;
    digit_idx_e        idx_q;
    logic              inv1, inv2;
    logic [1:0]        tens1, tens2;
    logic [3:0]        units1, units2;
    logic [6:0]        seg_d;
    logic [3:0]        an_d;

    // Tens digit pattern: dash for an invalid direction, optional zero blanking
    function automatic logic [6:0] tens_pattern(input logic inv, input logic [1:0] tens);
        if (inv) return SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
        if (tens == 2'd0) return SEG_BLANK;
`endif
        return seg_of_digit({2'b00, tens});
    endfunction

    // Seconds prescaler, wraps at TICK_DIV-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (presc_q == TICK_W'(TICK_DIV - 1)) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign sec_tick = (presc_q == TICK_W'(TICK_DIV - 1));

    phase_countdown #(
        .RED_TIME   (RED_TIME),
        .YELLOW_TIME(YELLOW_TIME),
        .GREEN_TIME (GREEN_TIME)
    ) u_dir1 (
        .clk    (clk),
        .reset  (reset),
        .light  (light1),
        .tick   (sec_tick),
        .cnt    (cnt1),
        .invalid(inv1)
    );

    phase_countdown #(
        .RED_TIME   (RED_TIME),
        .YELLOW_TIME(YELLOW_TIME),
        .GREEN_TIME (GREEN_TIME)
    ) u_dir2 (
        .clk    (clk),
        .reset  (reset),
        .light  (light2),
        .tick   (sec_tick),
        .cnt    (cnt2),
        .invalid(inv2)
    );

    // Scan counter; the digit index advances once per scan period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= DIG_D1_UNITS;
        end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= digit_idx_e'(idx_q + 2'd1);
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // BCD split and pattern for the slot selected by the current index
    always_comb begin
        tens1  = bcd_tens(cnt1);
        tens2  = bcd_tens(cnt2);
        units1 = bcd_units(cnt1, tens1);
        units2 = bcd_units(cnt2, tens2);
        seg_d  = SEG_BLANK;
        an_d   = ~(4'b0001 << idx_q);
        unique case (idx_q)
            DIG_D1_UNITS: seg_d = inv1 ? SEG_DASH : seg_of_digit(units1);
            DIG_D1_TENS:  seg_d = tens_pattern(inv1, tens1);
            DIG_D2_UNITS: seg_d = inv2 ? SEG_DASH : seg_of_digit(units2);
            DIG_D2_TENS:  seg_d = tens_pattern(inv2, tens2);
            default:      seg_d = SEG_BLANK;
        endcase
    end

    // an and seg registered together so the enable and pattern stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule
